// File: rtl/pool_pkg.sv
// Shared definitions for the pooling-engine scheduler: FSM encoding and sizing helpers.
package pool_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ARB   = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Ceiling log2; clog2(1) is 0.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Number of pooled windows produced per channel.
    function automatic int pool_out_per_ch(input int ifm, input int k, input int s);
        int side;
        side = (ifm - k) / s + 1;
        return side * side;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first active request at or after the pointer, wrapping.
module rr_arbiter
    import pool_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx
);

    // Scan upward from the pointer and keep the first hit.
    always_comb begin
        int   j;
        logic found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        j       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!found && req[j]) begin
                found      = 1'b1;
                gnt[j]     = 1'b1;
                gnt_idx    = j[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/pool_sched.sv
// Scheduler sharing one pooling engine among NUM_REQ producers, one full frame per grant.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   IDLE     | engine free, waiting for any request
//   ARB      | one cycle, round-robin pick of the next owner
//   RUN      | accepting pixels from the owner, tracking row/col/channel
//   DRAIN    | intake closed, waiting DRAIN_CYC cycles for engine flush
//   DONE     | one cycle, frame_done, release grant and advance RR pointer
module pool_sched
    import pool_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int IFM_SIZE    = 27,
    parameter int KERNEL_POOL = 5,
    parameter int STRIDE_POOL = 1,
    parameter int CI          = 3,
    parameter int DRAIN_CYC   = 7
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    output logic [NUM_REQ-1:0]           grant,
    output logic                         busy,
    input  logic                         pix_valid,
    output logic                         pix_ready,
    output logic                         set_ifm,
    output logic                         set_reg,
    output logic [clog2(IFM_SIZE)-1:0]   row_idx,
    output logic [clog2(IFM_SIZE)-1:0]   col_idx,
    output logic [clog2(CI):0]           ch_idx,
    output logic                         win_valid,
    output logic                         ch_done,
    output logic                         frame_done
);

    localparam int RW = clog2(IFM_SIZE);
    localparam int CW = clog2(CI) + 1;
    localparam int PW = clog2(STRIDE_POOL) + 1;
    localparam int DW = clog2(DRAIN_CYC) + 1;
    localparam int IW = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1;

    localparam logic [RW-1:0] LAST_POS   = RW'(IFM_SIZE - 1);
    localparam logic [RW-1:0] KM1        = RW'(KERNEL_POOL - 1);
    localparam logic [CW-1:0] LAST_CH    = CW'(CI - 1);
    localparam logic [PW-1:0] PH_LAST    = PW'(STRIDE_POOL - 1);
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYC - 1);
    localparam logic [IW-1:0] LAST_REQ   = IW'(NUM_REQ - 1);

    if (KERNEL_POOL > IFM_SIZE) begin : g_bad_kernel
        $error("pool_sched: KERNEL_POOL must not exceed IFM_SIZE");
    end
    if (STRIDE_POOL < 1) begin : g_bad_stride
        $error("pool_sched: STRIDE_POOL must be at least 1");
    end
    if (DRAIN_CYC < 1) begin : g_bad_drain
        $error("pool_sched: DRAIN_CYC must be at least 1");
    end

    logic [2:0]         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IW-1:0]      gidx_q, gidx_d, rr_ptr_q, rr_ptr_d;
    logic [RW-1:0]      col_q, col_d, row_q, row_d;
    logic [CW-1:0]      ch_q, ch_d;
    logic [PW-1:0]      cph_q, cph_d, rph_q, rph_d;
    logic [DW-1:0]      drain_q, drain_d;
    logic               set_ifm_q, set_ifm_d, set_reg_q, set_reg_d;
    logic               win_q, win_d, ch_done_q, ch_done_d, frame_done_q, frame_done_d;
    logic [RW-1:0]      row_idx_q, row_idx_d, col_idx_q, col_idx_d;
    logic [CW-1:0]      ch_idx_q, ch_idx_d;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [IW-1:0]      arb_idx;
    logic               accept, col_last, row_last, ch_last;
    logic [RW-1:0]      col_inc, row_inc;

    // Phase is (pos-K+1) mod S, restarted when pos reaches K-1; values below K-1 are ignored.
    function automatic logic [PW-1:0] next_phase(input logic [PW-1:0] ph, input logic [RW-1:0] pos);
        if (pos == KM1 || ph == PH_LAST) return '0;
        return ph + 1'b1;
    endfunction

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IW)
    ) u_arb (
        .req     (req),
        .ptr     (rr_ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    // Next-state, position counters and registered strobes.
    always_comb begin
        accept    = (state_q == ST_RUN) && pix_valid;
        col_last  = (col_q == LAST_POS);
        row_last  = (row_q == LAST_POS);
        ch_last   = (ch_q == LAST_CH);
        col_inc   = col_q + 1'b1;
        row_inc   = row_q + 1'b1;

        state_d      = state_q;
        grant_d      = grant_q;
        gidx_d       = gidx_q;
        rr_ptr_d     = rr_ptr_q;
        col_d        = col_q;
        row_d        = row_q;
        ch_d         = ch_q;
        cph_d        = cph_q;
        rph_d        = rph_q;
        drain_d      = drain_q;
        row_idx_d    = row_idx_q;
        col_idx_d    = col_idx_q;
        ch_idx_d     = ch_idx_q;
        set_ifm_d    = 1'b0;
        set_reg_d    = set_ifm_q;
        win_d        = 1'b0;
        ch_done_d    = 1'b0;
        frame_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|req) state_d = ST_ARB;
            end
            ST_ARB: begin
                if (|arb_gnt) begin
                    grant_d = arb_gnt;
                    gidx_d  = arb_idx;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    set_ifm_d = 1'b1;
                    row_idx_d = row_q;
                    col_idx_d = col_q;
                    ch_idx_d  = ch_q;
                    win_d     = (row_q >= KM1) && (col_q >= KM1) && (rph_q == '0) && (cph_q == '0);
                    ch_done_d = row_last && col_last;
                    if (col_last) begin
                        col_d = '0;
                        cph_d = '0;
                        if (row_last) begin
                            row_d = '0;
                            rph_d = '0;
                            ch_d  = ch_q + 1'b1;
                        end else begin
                            row_d = row_inc;
                            rph_d = next_phase(rph_q, row_inc);
                        end
                    end else begin
                        col_d = col_inc;
                        cph_d = next_phase(cph_q, col_inc);
                    end
                    if (row_last && col_last && ch_last) begin
                        state_d = ST_DRAIN;
                        drain_d = DRAIN_LOAD;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_q == '0) begin
                    state_d      = ST_DONE;
                    frame_done_d = 1'b1;
                    ch_idx_d     = '0;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            ST_DONE: begin
                grant_d   = '0;
                rr_ptr_d  = (gidx_q == LAST_REQ) ? '0 : gidx_q + 1'b1;
                col_d     = '0;
                row_d     = '0;
                ch_d      = '0;
                cph_d     = '0;
                rph_d     = '0;
                row_idx_d = '0;
                col_idx_d = '0;
                ch_idx_d  = '0;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            gidx_q       <= '0;
            rr_ptr_q     <= '0;
            col_q        <= '0;
            row_q        <= '0;
            ch_q         <= '0;
            cph_q        <= '0;
            rph_q        <= '0;
            drain_q      <= '0;
            row_idx_q    <= '0;
            col_idx_q    <= '0;
            ch_idx_q     <= '0;
            set_ifm_q    <= 1'b0;
            set_reg_q    <= 1'b0;
            win_q        <= 1'b0;
            ch_done_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            gidx_q       <= gidx_d;
            rr_ptr_q     <= rr_ptr_d;
            col_q        <= col_d;
            row_q        <= row_d;
            ch_q         <= ch_d;
            cph_q        <= cph_d;
            rph_q        <= rph_d;
            drain_q      <= drain_d;
            row_idx_q    <= row_idx_d;
            col_idx_q    <= col_idx_d;
            ch_idx_q     <= ch_idx_d;
            set_ifm_q    <= set_ifm_d;
            set_reg_q    <= set_reg_d;
            win_q        <= win_d;
            ch_done_q    <= ch_done_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign grant      = grant_q;
    assign busy       = (state_q != ST_IDLE);
    assign pix_ready  = (state_q == ST_RUN);
    assign set_ifm    = set_ifm_q;
    assign set_reg    = set_reg_q;
    assign row_idx    = row_idx_q;
    assign col_idx    = col_idx_q;
    assign ch_idx     = ch_idx_q;
    assign win_valid  = win_q;
    assign ch_done    = ch_done_q;
    assign frame_done = frame_done_q;

endmodule
